// File: rtl/dsm_integrator_chain.sv
// Cascade of ORDER pipelined accumulators forming the delta-sigma loop filter,
// with per-stage saturate/wrap arithmetic, a valid pipeline and a sticky overflow flag.
module dsm_integrator_chain #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 2,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [ACC_WIDTH-1:0]  o_data,
  output logic                         o_valid,
  output logic                         o_ovf
);

  generate
    if (ORDER < 1 || ORDER > 8 || ACC_WIDTH <= DATA_WIDTH) begin : g_param_check
      $error("dsm_integrator_chain: need 1 <= ORDER <= 8 and ACC_WIDTH > DATA_WIDTH");
    end
  endgenerate

  localparam logic [ACC_WIDTH-1:0] MAX_VAL = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MIN_VAL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ORDER-1:0][ACC_WIDTH-1:0] acc_bus;
  logic [ORDER-1:0]                v_reg;
  logic [ORDER:0]                  v_chain;
  logic [ORDER-1:0]                stage_ovf;
  logic                            ovf_reg;

  // v_chain[k] is the update enable of stage k (stage 0 is driven by i_en).
  assign v_chain = {v_reg, i_en};

  genvar gi;
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_stage
      logic [ACC_WIDTH-1:0] stage_in;
      logic [ACC_WIDTH-1:0] acc_reg;
      logic [ACC_WIDTH-1:0] acc_next;
      logic [ACC_WIDTH:0]   sum;
      logic                 sum_ovf;

      if (gi == 0) begin : g_first
        assign stage_in = {{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
      end else begin : g_rest
        assign stage_in = acc_bus[gi-1];
      end

      // One guard bit: the two top bits disagree exactly when the sum overflowed.
      assign sum     = {acc_reg[ACC_WIDTH-1], acc_reg} + {stage_in[ACC_WIDTH-1], stage_in};
      assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      assign stage_ovf[gi] = v_chain[gi] & sum_ovf;

      always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        if (SATURATE && sum_ovf) begin
          acc_next = sum[ACC_WIDTH] ? MIN_VAL : MAX_VAL;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          acc_reg <= '0;
        end else if (i_clr) begin
          acc_reg <= '0;
        end else if (v_chain[gi]) begin
          acc_reg <= acc_next;
        end
      end

      assign acc_bus[gi] = acc_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (i_clr) begin
      v_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      v_reg <= v_chain[ORDER-1:0];
      if (|stage_ovf) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign o_data  = acc_bus[ORDER-1];
  assign o_valid = v_reg[ORDER-1];
  assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_dsm_integrator_chain.sv
// Directed bench: a saturating and a wrapping ORDER=2 chain driven in parallel,
// checked against hand-computed vectors with immediate assertions.
module tb_dsm_integrator_chain;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic clr;
  logic signed [15:0] din;

  logic signed [19:0] s_data, w_data;
  logic s_valid, s_ovf, w_valid, w_ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsm_integrator_chain #(.DATA_WIDTH(16), .ORDER(2), .ACC_WIDTH(20), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_data(din),
    .o_data(s_data), .o_valid(s_valid), .o_ovf(s_ovf)
  );

  dsm_integrator_chain #(.DATA_WIDTH(16), .ORDER(2), .ACC_WIDTH(20), .SATURATE(1'b0)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_data(din),
    .o_data(w_data), .o_valid(w_valid), .o_ovf(w_ovf)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sat(input string tag, input int ev, input int ed, input int eo);
    chk({tag, " sat.valid"}, {31'd0, s_valid}, ev);
    chk({tag, " sat.data"},  s_data, ed);
    chk({tag, " sat.ovf"},   {31'd0, s_ovf}, eo);
  endtask

  task automatic chk_wrap(input string tag, input int ev, input int ed, input int eo);
    chk({tag, " wrap.valid"}, {31'd0, w_valid}, ev);
    chk({tag, " wrap.data"},  w_data, ed);
    chk({tag, " wrap.ovf"},   {31'd0, w_ovf}, eo);
  endtask

  task automatic chk_both(input string tag, input int ev, input int ed, input int eo);
    chk_sat(tag, ev, ed, eo);
    chk_wrap(tag, ev, ed, eo);
  endtask

  // Apply one clock edge with the given inputs, then settle just past the edge.
  task automatic cyc(input logic e, input logic c, input logic signed [15:0] d);
    en  = e;
    clr = c;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_step(input string tag);
    cyc(1'b1, 1'b0, 16'sd1); chk_both({tag, " e1"}, 0, 0, 0);
    cyc(1'b1, 1'b0, 16'sd1); chk_both({tag, " e2"}, 1, 1, 0);
    cyc(1'b1, 1'b0, 16'sd1); chk_both({tag, " e3"}, 1, 3, 0);
    cyc(1'b1, 1'b0, 16'sd1); chk_both({tag, " e4"}, 1, 6, 0);
    cyc(1'b0, 1'b0, 16'sd0); chk_both({tag, " e5"}, 1, 10, 0);
    cyc(1'b0, 1'b0, 16'sd0); chk_both({tag, " e6"}, 0, 10, 0);
  endtask

  int bub_v[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int bub_d[9] = '{0, 1, 1, 3, 3, 6, 6, 10, 10};
  int sat_v[7] = '{0, 1, 1, 1, 1, 1, 1};
  int sat_d[7] = '{0, 32767, 98301, 196602, 327670, 491505, 524287};
  int wrp_d[7] = '{0, 32767, 98301, 196602, 327670, 491505, -360469};
  int sat_o[7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    din   = '0;
    #2;
    chk_both("reset", 0, 0, 0);
    cyc(1'b0, 1'b0, 16'sd0);
    cyc(1'b0, 1'b0, 16'sd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'sd0);
    chk_both("idle", 0, 0, 0);

    run_step("step");

    // Clear together with a valid sample: the sample must be discarded.
    cyc(1'b1, 1'b1, 16'sd100); chk_both("clear", 0, 0, 0);
    cyc(1'b0, 1'b0, 16'sd0);   chk_both("clear hold", 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      cyc((i < 8) && (i % 2 == 0), 1'b0, 16'sd1);
      chk_both($sformatf("bubble e%0d", i + 1), bub_v[i], bub_d[i], 0);
    end

    // Asynchronous reset mid-run, observed before the next clock edge.
    rst_n = 1'b0;
    #1;
    chk_both("async reset", 0, 0, 0);
    cyc(1'b0, 1'b0, 16'sd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'sd0);
    chk_both("post reset idle", 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 16'sd32767);
      chk_sat($sformatf("sat e%0d", i + 1), sat_v[i], sat_d[i], sat_o[i]);
      chk_wrap($sformatf("wrap e%0d", i + 1), sat_v[i], wrp_d[i], sat_o[i]);
    end

    // Stage 1 stays positive through e14, so stage 2 holds the rail until then.
    for (int i = 8; i <= 14; i++) begin
      cyc(1'b1, 1'b0, -16'sd32768);
      chk_sat($sformatf("rail e%0d", i), 1, 524287, 1);
    end
    cyc(1'b1, 1'b0, -16'sd32768);
    chk_sat("leave rail e15", 1, 524280, 1);
    chk("wrap ovf sticky", {31'd0, w_ovf}, 1);

    cyc(1'b1, 1'b1, 16'sd100); chk_both("clear after ovf", 0, 0, 0);
    cyc(1'b0, 1'b0, 16'sd0);   chk_both("clear after ovf hold", 0, 0, 0);

    run_step("step after clear");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsm_integrator_chain.md
# dsm_integrator_chain

Parametrised cascade of ORDER pipelined accumulators used as the loop filter of the delta-sigma modulator. It generalises the single-stage integrator in three ways: stage count is configurable, overflow is either saturated or wrapped, and overflow is reported through a sticky flag. A synchronous clear and a valid pipeline let the modulator core reset loop state and track when the final-stage output is fresh.

## Interface
Parameters:
- DATA_WIDTH, 16, width of signed input sample.
- ORDER, 2, number of cascaded integrator stages (1..8).
- ACC_WIDTH, DATA_WIDTH+4, width of every stage accumulator (signed, > DATA_WIDTH).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_en  in  1  input sample valid; sample accepted on an edge where i_en=1.
- i_clr  in  1  synchronous clear of all loop state.
- i_data  in  DATA_WIDTH  signed input sample.
- o_data  out  ACC_WIDTH  signed output of the final stage (stage ORDER accumulator).
- o_valid  out  1  one-cycle pulse: o_data updated on the preceding edge.
- o_ovf  out  1  sticky overflow flag, any stage.

## Operation
- State: accumulators acc[1..ORDER] (ACC_WIDTH, signed), valid shift register v[1..ORDER], and the ovf register.
- Stage 1 input: i_data sign-extended to ACC_WIDTH. Stage k>1 input: the registered acc[k-1].
- Stage update: stage 1 updates when i_en=1. Stage k>1 updates when v[k-1]=1. On update, acc[k] <= f(acc[k] + input).
- Valid pipeline: v[1] <= i_en and v[k] <= v[k-1]. o_valid = v[ORDER].
- Arithmetic: the sum is formed at ACC_WIDTH+1 bits. Overflow occurs when the two MSBs of that sum differ.
  - SATURATE=1: clamp to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1), according to the sign of the extended sum.
  - SATURATE=0: keep the low ACC_WIDTH bits.
- o_ovf is set on any edge where any updating stage overflows, in either mode. It stays set until i_clr or reset.
- i_clr=1 has priority over i_en and v. On that edge, all acc, all v, and ovf go to 0, and the sample presented with i_clr is discarded.
- Bubbles (i_en=0) propagate through v. Stages that are not updating hold their value.
- Behaviour is undefined for ORDER<1 or ACC_WIDTH<=DATA_WIDTH. An elaboration-time check is required.

## Timing
- Reset (asynchronous, i_rst_n=0): all acc=0, all v=0, o_data=0, o_valid=0, o_ovf=0 immediately, without waiting for a clock edge.
- Reset deassertion mid-stream: the first edge with i_rst_n=1 processes inputs normally. No samples are replayed.
- Latency: a sample accepted at edge n reaches acc[k] at edge n+k-1. o_data reflects it after edge n+ORDER-1, with o_valid=1 during the following cycle.
- ORDER=1: acc[1] behaves exactly as a plain integrator. o_valid is i_en delayed by one cycle.
- Throughput: one sample per cycle. There is no backpressure.
- i_clr and i_en in the same cycle: the clear wins. The first accepted sample after the clear is the next edge with i_en=1 and i_clr=0.
- Overflow at the same edge as i_clr: o_ovf ends at 0.
- Saturated stage at the rail: it stays at the rail while its input keeps the same sign, and leaves the rail as soon as the input reverses sign.
- o_ovf goes high on the cycle after the offending edge.

## Test plan
- Reset/idle: assert i_rst_n=0 mid-run with nonzero acc -> o_data=0, o_valid=0, o_ovf=0 immediately. With i_en=0 afterwards, outputs hold 0.
- Impulse/step, ORDER=2, ACC_WIDTH=20: apply i_data=1 with i_en=1 for 4 cycles.
  - o_valid pulses on 4 consecutive cycles, starting 2 cycles after the first accepted edge.
  - o_data sequence is 1, 3, 6, 10. o_ovf stays 0.
- Bubble: repeat the step with i_en toggling 1,0,1,0,... -> o_data is again 1, 3, 6, 10, with o_valid pulses spaced 2 cycles apart.
- Saturation, SATURATE=1, ORDER=2, ACC_WIDTH=20: apply i_data=32767 continuously.
  - The 5th output is 491505.
  - The 6th output clamps to 524287, and o_ovf=1 from the next cycle.
  - Then apply i_data=-32768 -> acc[2] leaves the rail.
- Wrap, SATURATE=0, same stimulus -> the 6th output is -360469 and o_ovf=1.
- Clear: assert i_clr=1 together with i_en=1 and i_data=100 mid-stream.
  - Next cycle: all stages 0, o_ovf=0, o_valid=0.
  - A subsequent step of 1 reproduces 1, 3, 6, 10.
